// File: rtl/switch_word_loader_pkg.sv
// Shared types and sizes for the switch word loader.
package switch_word_loader_pkg;
  localparam int unsigned BYTES  = 4;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EMIT
  } state_t;
endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-count filter; rise pulses for one
// cycle when the filtered level goes high.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
        // The DB_CYCLES-th consecutive mismatch commits the new level.
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_rise  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
endmodule

// File: rtl/switch_word_loader.sv
// Assembles a 32-bit word from four debounced button presses of the 8 switches
// and publishes it on value with a one-cycle enable strobe.
module switch_word_loader
  import switch_word_loader_pkg::*;
#(
  parameter int unsigned DB_CYCLES      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              BTN,
  input  logic [BYTE_W-1:0] SW,
  input  logic              CLR,
  output logic [WORD_W-1:0] value,
  output logic              enable,
  output logic              busy,
  output logic [1:0]        byte_idx
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SW_W = WORD_W - BYTE_W;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BYTE_W-1:0]   r_sw_sync1;
  logic [BYTE_W-1:0]   r_sw_sync2;
  logic [SW_W-1:0]     r_shift;
  logic [SW_W-1:0]     w_shift_nxt;
  logic [1:0]          r_byte_idx;
  logic [1:0]          w_idx_nxt;
  logic [WORD_W-1:0]   r_value;
  logic [WORD_W-1:0]   w_value_nxt;
  logic [TW-1:0]       r_tmo;
  logic [TW-1:0]       w_tmo_nxt;
  logic                w_level;
  logic                w_rise;
  logic                w_press;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db (
    .CLK  (CLK),
    .RST_N(RST_N),
    .raw  (BTN),
    .level(w_level),
    .rise (w_rise)
  );

  assign w_press = w_rise & w_level;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sw_sync1 <= '0;
      r_sw_sync2 <= '0;
      r_state    <= IDLE;
      r_shift    <= '0;
      r_byte_idx <= '0;
      r_value    <= '0;
      r_tmo      <= '0;
    end else begin
      r_sw_sync1 <= SW;
      r_sw_sync2 <= r_sw_sync1;
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_byte_idx <= w_idx_nxt;
      r_value    <= w_value_nxt;
      r_tmo      <= w_tmo_nxt;
    end
  end

  // The fourth byte goes straight into value so enable and the new word coincide.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_byte_idx;
    w_value_nxt = r_value;
    w_tmo_nxt   = '0;
    case (r_state)
      IDLE: begin
        if (w_press) begin
          w_shift_nxt = {{(SW_W - BYTE_W){1'b0}}, r_sw_sync2};
          w_idx_nxt   = 2'd1;
          w_state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (w_press) begin
          if (r_byte_idx == 2'd3) begin
            w_value_nxt = {r_shift, r_sw_sync2};
            w_shift_nxt = '0;
            w_idx_nxt   = '0;
            w_state_nxt = EMIT;
          end else begin
            w_shift_nxt = {r_shift[SW_W-BYTE_W-1:0], r_sw_sync2};
            w_idx_nxt   = r_byte_idx + 2'd1;
          end
        end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
          w_shift_nxt = '0;
          w_idx_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      EMIT:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (CLR) begin
      w_state_nxt = IDLE;
      w_shift_nxt = '0;
      w_idx_nxt   = '0;
      w_value_nxt = '0;
      w_tmo_nxt   = '0;
    end
  end

  assign value    = r_value;
  assign enable   = (r_state == EMIT);
  assign busy     = (r_state == COLLECT);
  assign byte_idx = r_byte_idx;
endmodule

// File: tb/tb_switch_word_loader.sv
// Self-checking bench for switch_word_loader with short debounce/timeout settings.
module tb_switch_word_loader;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        BTN;
  logic [7:0]  SW;
  logic        CLR;
  logic [31:0] value;
  logic        enable;
  logic        busy;
  logic [1:0]  byte_idx;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned en_cnt = 0;
  int unsigned dbl_cnt = 0;
  logic        prev_en = 1'b0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] mdl_word = '0;
  int unsigned mdl_n = 0;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[3];

  switch_word_loader #(
    .DB_CYCLES     (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .BTN     (BTN),
    .SW      (SW),
    .CLR     (CLR),
    .value   (value),
    .enable  (enable),
    .busy    (busy),
    .byte_idx(byte_idx)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (RST_N) begin
      if (enable) begin
        en_cnt++;
        got_q.push_back(value);
        if (prev_en) dbl_cnt++;
      end
      prev_en = enable;
    end else begin
      prev_en = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  // Reference: first byte in the MSB, a word completes every fourth accepted press.
  task automatic model_press(input logic [7:0] b);
    mdl_word = (mdl_word << 8) | 32'(b);
    mdl_n++;
    if (mdl_n == 4) begin
      exp_q.push_back(mdl_word);
      mdl_n = 0;
      mdl_word = '0;
    end
  endtask

  task automatic press(input logic [7:0] b);
    @(negedge CLK);
    SW  = b;
    BTN = 1'b1;
    repeat (12) @(negedge CLK);
    BTN = 1'b0;
    repeat (12) @(negedge CLK);
    #1;
  endtask

  initial begin
    int unsigned e0;
    logic [31:0] v0;
    logic [7:0]  vb[4];
    logic [7:0]  rb;
    bit          found;

    tbl[0] = '{b0: 8'hDE, b1: 8'hAD, b2: 8'hBE, b3: 8'hEF, exp: 32'hDEADBEEF};
    tbl[1] = '{b0: 8'h01, b1: 8'h02, b2: 8'h03, b3: 8'h04, exp: 32'h01020304};
    tbl[2] = '{b0: 8'hFF, b1: 8'h00, b2: 8'hA5, b3: 8'h5A, exp: 32'hFF00A55A};

    RST_N = 1'b0; BTN = 1'b0; SW = '0; CLR = 1'b0;
    cycles(3);
    chk("reset_value", value, 32'h0);
    chk("reset_enable", 32'(enable), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_idx", 32'(byte_idx), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    cycles(4);

    for (int i = 0; i < 3; i++) begin
      vb[0] = tbl[i].b0; vb[1] = tbl[i].b1; vb[2] = tbl[i].b2; vb[3] = tbl[i].b3;
      e0 = en_cnt;
      got_q.delete();
      for (int k = 0; k < 4; k++) begin
        press(vb[k]);
        chk($sformatf("tbl%0d_busy%0d", i, k), 32'(busy), (k < 3) ? 32'd1 : 32'd0);
        chk($sformatf("tbl%0d_idx%0d", i, k), 32'(byte_idx), 32'((k + 1) % 4));
      end
      chk($sformatf("tbl%0d_strobes", i), en_cnt - e0, 32'd1);
      chk($sformatf("tbl%0d_value", i), value, tbl[i].exp);
      chk($sformatf("tbl%0d_strobe_value", i), (got_q.size() > 0) ? got_q[0] : 32'hX, tbl[i].exp);
    end

    // Timeout discards a partial word and leaves value alone.
    v0 = value;
    e0 = en_cnt;
    press(8'h12);
    press(8'h34);
    cycles(20);
    chk("tmo_busy_before", 32'(busy), 32'd1);
    chk("tmo_idx_before", 32'(byte_idx), 32'd2);
    cycles(40);
    chk("tmo_busy_after", 32'(busy), 32'd0);
    chk("tmo_idx_after", 32'(byte_idx), 32'd0);
    chk("tmo_no_strobe", en_cnt - e0, 32'd0);
    chk("tmo_value_kept", value, v0);

    // CLR coincident with the fourth press pulse.
    e0 = en_cnt;
    press(8'h11);
    press(8'h22);
    press(8'h33);
    chk("clr_idx3", 32'(byte_idx), 32'd3);
    @(negedge CLK);
    SW = 8'h44;
    BTN = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      if (dut.w_press) begin
        CLR = 1'b1;
        found = 1'b1;
        break;
      end
    end
    @(negedge CLK);
    CLR = 1'b0;
    repeat (10) @(negedge CLK);
    chk("clr_held_idx", 32'(byte_idx), 32'd0);
    BTN = 1'b0;
    cycles(12);
    chk("clr_press_seen", 32'(found), 32'd1);
    chk("clr_no_strobe", en_cnt - e0, 32'd0);
    chk("clr_value", value, 32'h0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_idx", 32'(byte_idx), 32'd0);

    // Bouncing button settles into exactly one press.
    @(negedge CLK);
    SW = 8'h5C;
    for (int t = 0; t < 5; t++) begin
      BTN = 1'b1;
      repeat (2) @(negedge CLK);
      BTN = 1'b0;
      repeat (2) @(negedge CLK);
    end
    #1;
    chk("bounce_idx_during", 32'(byte_idx), 32'd0);
    @(negedge CLK);
    BTN = 1'b1;
    cycles(12);
    chk("bounce_idx", 32'(byte_idx), 32'd1);
    chk("bounce_busy", 32'(busy), 32'd1);
    @(negedge CLK);
    BTN = 1'b0;
    repeat (12) @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    cycles(2);
    chk("bounce_clr_busy", 32'(busy), 32'd0);

    // Back-to-back random words against the reference model.
    got_q.delete();
    exp_q.delete();
    mdl_n = 0;
    mdl_word = '0;
    e0 = en_cnt;
    for (int p = 0; p < 20; p++) begin
      rb = 8'($urandom_range(0, 255));
      press(rb);
      model_press(rb);
    end
    chk("rand_strobes", en_cnt - e0, 32'(exp_q.size()));
    for (int w = 0; w < exp_q.size(); w++)
      chk($sformatf("rand_word%0d", w), (w < got_q.size()) ? got_q[w] : 32'hX, exp_q[w]);
    chk("rand_last_value", value, exp_q[exp_q.size() - 1]);

    // Reset mid-word: outputs clear immediately and no strobe follows.
    press(8'hA1);
    press(8'hB2);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("rst_mid_value", value, 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_idx", 32'(byte_idx), 32'd0);
    chk("rst_mid_enable", 32'(enable), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    e0 = en_cnt;
    cycles(30);
    chk("rst_mid_no_strobe", en_cnt - e0, 32'd0);
    chk("rst_mid_busy_after", 32'(busy), 32'd0);

    chk("enable_never_double", dbl_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
